// File: rtl/qr_result_serializer_pkg.sv
// Shared constants and element bit-slice helpers for the QR result bus.
// Element offsets match the QR engine's packing of R and y-hat.
package qr_result_serializer_pkg;

    localparam int N_R         = 10;
    localparam int N_Y         = 4;
    localparam int FRAME_WORDS = 14;
    localparam int R_W         = 16;
    localparam int Y_W         = 20;
    localparam int WORD_W      = 2 * Y_W;

    typedef logic [3:0] word_idx_t;

    function automatic int r_elem_lsb(input int k, input int r_w);
        return 2 * r_w * k;
    endfunction

    function automatic int y_elem_lsb(input int j, input int y_w);
        return 2 * y_w * j;
    endfunction

endpackage

// File: rtl/qr_result_serializer_if.sv
// Frame input bus plus the 40-bit valid/ready word stream of the serializer.
interface qr_result_serializer_if
    import qr_result_serializer_pkg::*;
#(
    parameter int R_W = qr_result_serializer_pkg::R_W,
    parameter int Y_W = qr_result_serializer_pkg::Y_W
);
    logic                   i_vld;
    logic                   i_last;
    logic [N_R*2*R_W-1:0]   i_r;
    logic [N_Y*2*Y_W-1:0]   i_y_hat;
    logic                   o_vld;
    logic                   i_rdy;
    logic [2*Y_W-1:0]       o_data;
    word_idx_t              o_idx;
    logic                   o_sof;
    logic                   o_eof;
    logic                   o_last;
    logic                   o_overflow;
    logic                   o_busy;

    modport slave (
        input  i_vld, i_last, i_r, i_y_hat, i_rdy,
        output o_vld, o_data, o_idx, o_sof, o_eof, o_last, o_overflow, o_busy
    );

    modport master (
        output i_vld, i_last, i_r, i_y_hat, i_rdy,
        input  o_vld, o_data, o_idx, o_sof, o_eof, o_last, o_overflow, o_busy
    );
endinterface

// File: rtl/qr_frame_fifo.sv
// Whole-frame FIFO; a push while full is accepted when the head pops in the same cycle.
module qr_frame_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 481
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         empty_next,
    output logic         push_ok
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             full, pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok)
            count_next = count + 1'b1;
        else if (pop_ok && !push_ok)
            count_next = count - 1'b1;
    end

    assign empty_next = (count_next == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/qr_result_serializer.sv
// Buffers QR result frames and streams each as 14 sign-extended complex words.
//   state   | meaning
//   IDLE    | FIFO empty, no word presented
//   SEND    | presenting word cnt of the head frame
module qr_result_serializer
    import qr_result_serializer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int R_W   = qr_result_serializer_pkg::R_W,
    parameter int Y_W   = qr_result_serializer_pkg::Y_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    qr_result_serializer_if.slave    bus
);
    localparam int R_BUS_W = N_R * 2 * R_W;
    localparam int Y_BUS_W = N_Y * 2 * Y_W;
    localparam int FRAME_W = 1 + R_BUS_W + Y_BUS_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]         state;
    word_idx_t          cnt;
    logic               overflow;
    logic [FRAME_W-1:0] head;
    logic [R_BUS_W-1:0] head_r;
    logic [Y_BUS_W-1:0] head_y;
    logic [2*Y_W-1:0]   word;
    logic [R_W-1:0]     re, im;
    logic               empty, empty_next, push_ok;
    logic               sending, xfer, last_word, pop;

    assign sending   = (state == ST_SEND);
    assign xfer      = sending & bus.i_rdy;
    assign last_word = (cnt == word_idx_t'(FRAME_WORDS - 1));
    assign pop       = xfer & last_word;

    qr_frame_fifo #(.DEPTH(DEPTH), .W(FRAME_W)) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .push       (bus.i_vld),
        .pop        (pop),
        .wr_data    ({bus.i_last, bus.i_r, bus.i_y_hat}),
        .rd_data    (head),
        .empty      (empty),
        .empty_next (empty_next),
        .push_ok    (push_ok)
    );

    // Looking at the next-cycle FIFO occupancy lets word 0 appear one cycle after
    // the push and lets back-to-back frames stream without a bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.i_vld && !push_ok) overflow <= 1'b1;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!empty_next) state <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (last_word) begin
                            cnt <= '0;
                            if (empty_next) state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign head_r = head[FRAME_W-2 -: R_BUS_W];
    assign head_y = head[Y_BUS_W-1:0];

    always_comb begin
        word = '0;
        re   = '0;
        im   = '0;
        for (int k = 0; k < N_R; k++) begin
            if (cnt == word_idx_t'(k)) begin
                re   = head_r[r_elem_lsb(k, R_W) + R_W +: R_W];
                im   = head_r[r_elem_lsb(k, R_W) +: R_W];
                word = {{(Y_W-R_W){re[R_W-1]}}, re, {(Y_W-R_W){im[R_W-1]}}, im};
            end
        end
        for (int j = 0; j < N_Y; j++) begin
            if (cnt == word_idx_t'(N_R + j))
                word = head_y[y_elem_lsb(j, Y_W) +: 2*Y_W];
        end
    end

    assign bus.o_vld      = sending;
    assign bus.o_data     = sending ? word : '0;
    assign bus.o_idx      = sending ? cnt : '0;
    assign bus.o_sof      = sending & (cnt == '0);
    assign bus.o_eof      = sending & last_word;
    assign bus.o_last     = sending & last_word & head[FRAME_W-1];
    assign bus.o_overflow = overflow;
    assign bus.o_busy     = ~empty | sending;

endmodule

// File: tb/tb_qr_result_serializer.sv
// Directed bench for qr_result_serializer: reset, streaming, stalls, overflow and batch end.
module tb_qr_result_serializer;
    import qr_result_serializer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    qr_result_serializer_if #(.R_W(16), .Y_W(20)) bus ();

    qr_result_serializer #(.DEPTH(2), .R_W(16), .Y_W(20)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [319:0] fr_r [10];
    logic [159:0] fr_y [10];
    logic         fr_last [10];

    function automatic logic [39:0] exp_word(input int id, input int k);
        logic [31:0]  e;
        logic [319:0] r;
        logic [159:0] y;
        r = fr_r[id];
        y = fr_y[id];
        if (k < 10) begin
            e = r[32*k +: 32];
            return {{4{e[31]}}, e[31:16], {4{e[15]}}, e[15:0]};
        end
        return y[40*(k-10) +: 40];
    endfunction

    task automatic build_frames();
        for (int id = 0; id < 10; id++) begin
            for (int k = 0; k < 10; k++)
                fr_r[id][32*k +: 32] = {16'(k*9029 + id*7967), 16'(~(k*1799) + id*3)};
            for (int j = 0; j < 4; j++)
                fr_y[id][40*j +: 40] = {20'(j*201234 + id*17), 20'(1048000 - j*id*4099)};
            fr_last[id] = (id == 9);
        end
        fr_r[0][31:0]    = 32'h8000_7FFF;
        fr_y[0][159:120] = 40'h00001_FFFFF;
    endtask

    task automatic push(input int id);
        bus.i_vld   = 1'b1;
        bus.i_last  = fr_last[id];
        bus.i_r     = fr_r[id];
        bus.i_y_hat = fr_y[id];
        @(negedge clk);
        bus.i_vld  = 1'b0;
        bus.i_last = 1'b0;
    endtask

    task automatic do_reset();
        bus.i_vld = 1'b0;
        bus.i_rdy = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input int first, input int nframes, input bit strict);
        int w = 0;
        int waits = 0;
        int id, k;
        bus.i_rdy = 1'b1;
        while (w < nframes*14) begin
            if (bus.o_vld) begin
                id = first + w / 14;
                k  = w % 14;
                vectors++;
                if (bus.o_idx !== 4'(k) || bus.o_data !== exp_word(id, k) ||
                    bus.o_sof !== 1'(k == 0) || bus.o_eof !== 1'(k == 13) ||
                    bus.o_last !== 1'(fr_last[id] && k == 13)) begin
                    miscompares++;
                    $display("FAIL drain f%0d w%0d: got idx=%0d data=%h sof=%b eof=%b last=%b, want idx=%0d data=%h sof=%b eof=%b last=%b",
                             id, k, bus.o_idx, bus.o_data, bus.o_sof, bus.o_eof, bus.o_last,
                             k, exp_word(id, k), k == 0, k == 13, fr_last[id] && k == 13);
                end
                w++;
                waits = 0;
            end else begin
                if (strict) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL drain bubble before word %0d: got o_vld=0, want 1", w);
                end
                waits++;
                if (waits > 20) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL drain timeout: got %0d words, want %0d", w, nframes*14);
                    break;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.i_rdy   = 1'b1;
        bus.i_r     = fr_r[0];
        bus.i_y_hat = fr_y[0];
        bus.i_last  = 1'b1;
        bus.i_vld   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.o_vld, bus.o_sof, bus.o_eof, bus.o_last, bus.o_overflow, bus.o_busy} !== 6'b0 ||
            bus.o_data !== 40'h0 || bus.o_idx !== 4'h0) begin
            miscompares++;
            $display("FAIL reset outputs: got vld=%b data=%h idx=%0d sof=%b eof=%b last=%b ovf=%b busy=%b, want all 0",
                     bus.o_vld, bus.o_data, bus.o_idx, bus.o_sof, bus.o_eof, bus.o_last,
                     bus.o_overflow, bus.o_busy);
        end
        bus.i_vld  = 1'b0;
        bus.i_last = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_vld !== 1'b0 || bus.o_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset idle c%0d: got vld=%b busy=%b, want 0 0", c, bus.o_vld, bus.o_busy);
            end
        end
    endtask

    task automatic test_single();
        bus.i_rdy = 1'b1;
        push(0);
        for (int w = 0; w < 14; w++) begin
            vectors++;
            if (bus.o_vld !== 1'b1 || bus.o_idx !== 4'(w) || bus.o_data !== exp_word(0, w) ||
                bus.o_sof !== 1'(w == 0) || bus.o_eof !== 1'(w == 13)) begin
                miscompares++;
                $display("FAIL single w%0d: got vld=%b idx=%0d data=%h sof=%b eof=%b, want 1 %0d %h %b %b",
                         w, bus.o_vld, bus.o_idx, bus.o_data, bus.o_sof, bus.o_eof,
                         w, exp_word(0, w), w == 0, w == 13);
            end
            if (w == 0) begin
                vectors++;
                if (bus.o_data !== 40'hF8000_07FFF || bus.o_sof !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single word0 sext: got %h sof=%b, want f800007fff 1", bus.o_data, bus.o_sof);
                end
            end
            if (w == 13) begin
                vectors++;
                if (bus.o_data !== 40'h00001_FFFFF || bus.o_eof !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single word13: got %h eof=%b, want 00001fffff 1", bus.o_data, bus.o_eof);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (bus.o_vld !== 1'b0 || bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single end: got vld=%b busy=%b, want 0 0", bus.o_vld, bus.o_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  pat = 4'b1001;
        logic [39:0] saved_data = '0;
        logic [3:0]  saved_idx = '0;
        bit          stall_prev = 1'b0;
        int          got = 0;
        int          cyc = 0;
        bus.i_rdy = 1'b0;
        push(1);
        while (got < 14 && cyc < 100) begin
            bus.i_rdy = pat[cyc % 4];
            if (stall_prev) begin
                vectors++;
                if (bus.o_data !== saved_data || bus.o_idx !== saved_idx || bus.o_vld !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall hold c%0d: got vld=%b idx=%0d data=%h, want 1 %0d %h",
                             cyc, bus.o_vld, bus.o_idx, bus.o_data, saved_idx, saved_data);
                end
            end
            if (bus.o_vld && bus.i_rdy) begin
                vectors++;
                if (bus.o_idx !== 4'(got) || bus.o_data !== exp_word(1, got)) begin
                    miscompares++;
                    $display("FAIL stall xfer %0d: got idx=%0d data=%h, want %0d %h",
                             got, bus.o_idx, bus.o_data, got, exp_word(1, got));
                end
                got++;
            end
            stall_prev = bus.o_vld && !bus.i_rdy;
            saved_data = bus.o_data;
            saved_idx  = bus.o_idx;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (got != 14) begin
            miscompares++;
            $display("FAIL stall count: got %0d transfers, want 14", got);
        end
        bus.i_rdy = 1'b1;
    endtask

    task automatic test_overflow();
        do_reset();
        push(2);
        push(3);
        vectors++;
        if (bus.o_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow early: got %b, want 0", bus.o_overflow);
        end
        push(4);
        vectors++;
        if (bus.o_overflow !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_vld !== 1'b1 || bus.o_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL overflow set: got ovf=%b busy=%b vld=%b idx=%0d, want 1 1 1 0",
                     bus.o_overflow, bus.o_busy, bus.o_vld, bus.o_idx);
        end
        drain(2, 2, 1'b1);
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.o_vld !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow after drain: got vld=%b busy=%b ovf=%b, want 0 0 1",
                     bus.o_vld, bus.o_busy, bus.o_overflow);
        end
    endtask

    task automatic test_push_full_pop();
        do_reset();
        push(5);
        push(6);
        bus.i_rdy = 1'b1;
        for (int w = 0; w < 14; w++) begin
            vectors++;
            if (bus.o_vld !== 1'b1 || bus.o_idx !== 4'(w) || bus.o_data !== exp_word(5, w)) begin
                miscompares++;
                $display("FAIL pushpop head w%0d: got vld=%b idx=%0d data=%h, want 1 %0d %h",
                         w, bus.o_vld, bus.o_idx, bus.o_data, w, exp_word(5, w));
            end
            if (w == 13) begin
                bus.i_vld   = 1'b1;
                bus.i_last  = fr_last[7];
                bus.i_r     = fr_r[7];
                bus.i_y_hat = fr_y[7];
            end
            @(negedge clk);
        end
        bus.i_vld = 1'b0;
        vectors++;
        if (bus.o_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL pushpop overflow: got %b, want 0", bus.o_overflow);
        end
        drain(6, 2, 1'b1);
        vectors++;
        if (bus.o_overflow !== 1'b0 || bus.o_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL pushpop end: got ovf=%b vld=%b, want 0 0", bus.o_overflow, bus.o_vld);
        end
    endtask

    task automatic test_batch_end();
        bus.i_rdy = 1'b0;
        push(8);
        push(9);
        drain(8, 2, 1'b1);
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_vld !== 1'b0 || bus.o_last !== 1'b0) begin
            miscompares++;
            $display("FAIL batch end: got busy=%b vld=%b last=%b, want 0 0 0",
                     bus.o_busy, bus.o_vld, bus.o_last);
        end
    endtask

    initial begin
        bus.i_vld   = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_rdy   = 1'b0;
        bus.i_r     = '0;
        bus.i_y_hat = '0;
        build_frames();
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_push_full_pop();
        test_batch_end();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want completion before 200000");
        $fatal(1);
    end

endmodule

// File: doc/qr_result_serializer.md
Name: qr_result_serializer

Overview:
- Downstream of the QR engine; consumes its per-frame result bus (R upper-triangular matrix plus ŷ vector) on each read-valid pulse.
- Buffers whole frames in a small frame FIFO and serializes each frame as 14 sign-extended complex words over a 40-bit valid/ready stream.
- Decouples the engine's fixed-rate output from a back-pressuring consumer (detector or testbench sink); flags dropped frames.

Parameters:
- DEPTH, 2, frames of storage (≥1); pointers wrap modulo DEPTH.
- R_W, 16, bits per real/imag component of an R element.
- Y_W, 20, bits per real/imag component of a ŷ element; also the output component width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_vld  in  1  frame strobe (engine read-valid), one cycle per frame
- i_last  in  1  frame is last of batch; sampled with i_vld
- i_r  in  320  10 R elements, element k = i_r[32k+31:32k], {re[31:16], im[15:0]}
- i_y_hat  in  160  4 ŷ elements, element j = i_y_hat[40j+39:40j], {re[39:20], im[19:0]}
- o_vld  out  1  output word valid
- i_rdy  in  1  consumer ready
- o_data  out  40  {re[39:20], im[19:0]}, both two's complement
- o_idx  out  4  word index in frame, 0..13
- o_sof  out  1  high with word 0
- o_eof  out  1  high with word 13
- o_last  out  1  high with word 13 of a frame captured with i_last
- o_overflow  out  1  sticky: a frame was dropped
- o_busy  out  1  FIFO non-empty or a frame in transmission

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, FSM IDLE, word counter 0, overflow cleared. Reset mid-frame aborts the frame; no partial words survive.
- Push: i_vld=1 and FIFO not full → store {i_last, i_r, i_y_hat} at write pointer. Full → frame dropped, o_overflow set next cycle, stays set until reset.
- Simultaneous push and final pop (word 13 accepted) while full: the push is accepted; the slot frees in the same cycle.
- FSM IDLE: FIFO non-empty → SEND, counter=0; o_vld rises the cycle after the push lands (first word 1 cycle after i_vld when empty).
- FSM SEND: o_vld=1; o_data/o_idx/o_sof/o_eof/o_last stable while o_vld=1 and i_rdy=0. Transfer = o_vld & i_rdy; counter increments per transfer.
- On transfer at counter 13: pop head. If FIFO is still non-empty, including a push in the same cycle, stay SEND with counter 0 and no bubble; otherwise go IDLE with o_vld=0 next cycle.
- Word mapping, k=0..9: R element k; each 16-bit component sign-extended to 20 bits. k=10..13: ŷ element k-10, passed unchanged.
- i_rdy is ignored when o_vld=0. i_last without i_vld is ignored.
- Throughput: 14 cycles per frame at i_rdy=1. Engine frame spacing ≥14 cycles never overflows with DEPTH≥1.

Decomposition:
- Shared package: N_R=10, N_Y=4, FRAME_WORDS=14, WORD_W=40, R_W, Y_W, and element bit-slice offset functions shared with the QR engine.
- Sub-module qr_frame_fifo: DEPTH × 481-bit storage, wr/rd pointers, full/empty, same-cycle push-at-full-with-pop. The serializer top holds the FSM, counter and word mux.

Test Plan:
- Reset: hold i_rst_n=0 with i_vld=1 → all outputs 0; after release, no o_vld until the next i_vld.
- Single frame, i_rdy=1: R element 0 = 0x8000_7FFF, ŷ element 3 = 0x00001_FFFFF → word0 = 0xF8000_07FFF with o_sof=1; word13 = 0x00001_FFFFF with o_eof=1; o_vld first at i_vld+1 cycle, 14 consecutive transfers.
- Back-pressure: i_rdy toggles 1,0,0,1 → o_data/o_idx held across stalls; indices 0..13 each appear exactly once.
- Overflow: DEPTH=2, i_rdy=0, three i_vld pulses → o_overflow=1 after the third; i_rdy=1 then delivers 28 words from frames 1 and 2 only.
- Push at full with pop: full FIFO, i_vld coincides with word 13 transfer → no overflow; the next frame starts with no idle cycle.
- Batch end: frame with i_last=1 → o_last=1 only with that frame's word 13; o_busy falls the cycle after.
